mb_host_seq: RTL and testbench

//  Host-side sequencer that drives the Math Box from the game CPU bus domain. Accepts one command
//  (register address, operand byte, readback flag), presents EAB/EDB, pulses MStart, waits for the

---
 rtl/mb_host_pkg.sv | 29 ++
 rtl/mb_host_wait_ctr.sv | 27 ++
 rtl/mb_host_seq.sv | 208 ++++++++++++++++++++
 tb/tb_mb_host_seq.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_host_pkg.sv
// Shared types and default timing for the Math Box host sequencer.
package mb_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_START = 3'd2,
        ST_ARM   = 3'd3,
        ST_BUSY  = 3'd4,
        ST_RDLO  = 3'd5,
        ST_RDHI  = 3'd6,
        ST_RESP  = 3'd7
    } state_t;

    localparam int MSTART_CYCLES_DEF  = 2;
    localparam int MIN_WAIT_DEF       = 4;
    localparam int READ_LAT_DEF       = 1;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    localparam int WAIT_W = 8;

    localparam logic [15:0] RSP_TIMEOUT_DATA = 16'hFFFF;

    // A phase of N cycles is timed by loading N-1 and leaving when the count hits zero.
    function automatic logic [WAIT_W-1:0] wait_load(input int cycles);
        return WAIT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mb_host_wait_ctr.sv
// Loadable down-counter with zero flag; the controller only decrements while non-zero.
module mb_host_wait_ctr #(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mb_host_seq.sv
// Math Box host sequencer: one command in, optional 16-bit result out.
// Optional BUSY timeout enabled by defining MB_HOST_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | CMD_READY=1, waiting for a command
//   DRIVE | EAB/EDB presented, one settle cycle
//   START | MB_MSTART high for MSTART_CYCLES
//   ARM   | MIN_WAIT cycles ignoring MB_STOP
//   BUSY  | waiting for MB_STOP=1 (or timeout)
//   RDLO  | MB_YLO strobe, capture low byte
//   RDHI  | MB_YHI strobe, capture high byte
//   RESP  | RSP_VALID=1 until RSP_READY
module mb_host_seq
    import mb_host_pkg::*;
#(
    parameter int MSTART_CYCLES  = MSTART_CYCLES_DEF,
    parameter int MIN_WAIT       = MIN_WAIT_DEF,
    parameter int READ_LAT       = READ_LAT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        E6MHZ,
    input  logic        RESET_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [7:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA,
    input  logic        CMD_READBACK,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_DATA,
    output logic        RSP_TIMEOUT,
    output logic [7:0]  MB_EAB,
    output logic [7:0]  MB_EDB,
    output logic        MB_MSTART,
    input  logic        MB_STOP,
    output logic        MB_YLO,
    output logic        MB_YHI,
    input  logic [7:0]  MB_EDB_IN
);

    state_t              state;
    logic                rb_q;
    logic                ctr_load;
    logic                ctr_dec;
    logic                ctr_zero;
    logic [WAIT_W-1:0]   ctr_val;

    // The phase counter is reloaded on the edge that enters each timed state.
    always_comb begin
        ctr_load = 1'b0;
        ctr_val  = '0;
        ctr_dec  = 1'b0;
        case (state)
            ST_DRIVE: begin
                ctr_load = 1'b1;
                ctr_val  = wait_load(MSTART_CYCLES);
            end
            ST_START: begin
                if (ctr_zero) begin
                    ctr_load = rb_q;
                    ctr_val  = wait_load(MIN_WAIT);
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_ARM: ctr_dec = !ctr_zero;
            ST_BUSY: begin
                if (MB_STOP) begin
                    ctr_load = 1'b1;
                    ctr_val  = wait_load(READ_LAT);
                end
            end
            ST_RDLO: begin
                if (ctr_zero) begin
                    ctr_load = 1'b1;
                    ctr_val  = wait_load(READ_LAT);
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            ST_RDHI: ctr_dec = !ctr_zero;
            default: ;
        endcase
    end

    mb_host_wait_ctr #(.W(WAIT_W)) u_phase_ctr (
        .clk_sys  (E6MHZ),
        .rst_n    (RESET_N),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dec      (ctr_dec),
        .zero     (ctr_zero)
    );

`ifdef MB_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic to_load;
    logic to_dec;
    logic to_zero;

    assign to_load = (state == ST_ARM) && ctr_zero;
    assign to_dec  = (state == ST_BUSY) && !MB_STOP && !to_zero;

    mb_host_wait_ctr #(.W(TO_W)) u_timeout_ctr (
        .clk_sys  (E6MHZ),
        .rst_n    (RESET_N),
        .load     (to_load),
        .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
        .dec      (to_dec),
        .zero     (to_zero)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign RSP_TIMEOUT = 1'b0;
`endif

    always_ff @(posedge E6MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            rb_q      <= 1'b0;
            CMD_READY <= 1'b1;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            MB_EAB    <= '0;
            MB_EDB    <= '0;
            MB_MSTART <= 1'b0;
            MB_YLO    <= 1'b0;
            MB_YHI    <= 1'b0;
`ifdef MB_HOST_TIMEOUT_EN
            RSP_TIMEOUT <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        MB_EAB    <= CMD_ADDR;
                        MB_EDB    <= CMD_DATA;
                        rb_q      <= CMD_READBACK;
                        CMD_READY <= 1'b0;
`ifdef MB_HOST_TIMEOUT_EN
                        RSP_TIMEOUT <= 1'b0;
`endif
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    MB_MSTART <= 1'b1;
                    state     <= ST_START;
                end
                ST_START: begin
                    if (ctr_zero) begin
                        MB_MSTART <= 1'b0;
                        if (rb_q) begin
                            state <= ST_ARM;
                        end else begin
                            CMD_READY <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_ARM: begin
                    if (ctr_zero) state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (MB_STOP) begin
                        MB_YLO <= 1'b1;
                        state  <= ST_RDLO;
                    end
`ifdef MB_HOST_TIMEOUT_EN
                    else if (to_zero) begin
                        RSP_DATA    <= RSP_TIMEOUT_DATA;
                        RSP_TIMEOUT <= 1'b1;
                        RSP_VALID   <= 1'b1;
                        state       <= ST_RESP;
                    end
`endif
                end
                ST_RDLO: begin
                    if (ctr_zero) begin
                        RSP_DATA[7:0] <= MB_EDB_IN;
                        MB_YLO        <= 1'b0;
                        MB_YHI        <= 1'b1;
                        state         <= ST_RDHI;
                    end
                end
                ST_RDHI: begin
                    if (ctr_zero) begin
                        RSP_DATA[15:8] <= MB_EDB_IN;
                        MB_YHI         <= 1'b0;
                        RSP_VALID      <= 1'b1;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mb_host_seq.sv
// Self-checking bench for mb_host_seq with a behavioural Math Box model.
module tb_mb_host_seq;

    logic        E6MHZ = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [7:0]  CMD_ADDR = 8'h00;
    logic [7:0]  CMD_DATA = 8'h00;
    logic        CMD_READBACK = 1'b0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic [15:0] RSP_DATA;
    logic        RSP_TIMEOUT;
    logic [7:0]  MB_EAB;
    logic [7:0]  MB_EDB;
    logic        MB_MSTART;
    logic        MB_STOP = 1'b1;
    logic        MB_YLO;
    logic        MB_YHI;
    logic [7:0]  MB_EDB_IN;

    mb_host_seq dut (
        .E6MHZ        (E6MHZ),
        .RESET_N      (RESET_N),
        .CMD_VALID    (CMD_VALID),
        .CMD_READY    (CMD_READY),
        .CMD_ADDR     (CMD_ADDR),
        .CMD_DATA     (CMD_DATA),
        .CMD_READBACK (CMD_READBACK),
        .RSP_VALID    (RSP_VALID),
        .RSP_READY    (RSP_READY),
        .RSP_DATA     (RSP_DATA),
        .RSP_TIMEOUT  (RSP_TIMEOUT),
        .MB_EAB       (MB_EAB),
        .MB_EDB       (MB_EDB),
        .MB_MSTART    (MB_MSTART),
        .MB_STOP      (MB_STOP),
        .MB_YLO       (MB_YLO),
        .MB_YHI       (MB_YHI),
        .MB_EDB_IN    (MB_EDB_IN)
    );

    always #5 E6MHZ = ~E6MHZ;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        rb;
        logic [15:0] result;
        int          len;
        int          lat;
        logic [15:0] exp_data;
    } vec_t;

    int n_checks = 0;
    int n_pass = 0;

    int cyc = 0;
    bit stop_hist [0:65535];
    int acc_cyc = 0, n_acc = 0, rsp_cyc = 0, n_rsp = 0, hs_cyc = 0, rdy_cyc = 0;
    logic [15:0] rsp_cap = '0;
    logic        rsp_to_cap = 1'b0;
    int mst_run = 0, mst_width = 0, n_mst = 0, n_ylo = 0, n_yhi = 0, n_overlap = 0;
    bit rsp_prev = 0, ylo_prev = 0, yhi_prev = 0, rdy_prev = 0;

    // Math Box model: MStart reloads a busy count; STOP is 1 whenever the count is exhausted.
    int          mb_cnt = 0;
    int          mb_len = 0;
    bit          mb_hang = 0;
    logic [15:0] mb_result = '0;

    assign MB_EDB_IN = MB_YLO ? mb_result[7:0] : (MB_YHI ? mb_result[15:8] : 8'h00);

    always @(posedge E6MHZ) cyc++;

    always @(negedge E6MHZ) begin
        if (MB_MSTART) mb_cnt = mb_len;
        else if (mb_cnt > 0) mb_cnt--;
        MB_STOP = !mb_hang && (mb_cnt == 0);
        if (cyc < 65536) stop_hist[cyc] = MB_STOP;
        if (RESET_N) begin
            if (CMD_VALID && CMD_READY) begin acc_cyc = cyc; n_acc++; end
            if (RSP_VALID && !rsp_prev) begin
                rsp_cyc = cyc; n_rsp++; rsp_cap = RSP_DATA; rsp_to_cap = RSP_TIMEOUT;
            end
            if (RSP_VALID && RSP_READY) hs_cyc = cyc;
            if (CMD_READY && !rdy_prev) rdy_cyc = cyc;
            if (MB_MSTART) mst_run++;
            else if (mst_run > 0) begin mst_width = mst_run; n_mst++; mst_run = 0; end
            if (MB_YLO && !ylo_prev) n_ylo++;
            if (MB_YHI && !yhi_prev) n_yhi++;
            if (MB_YLO && MB_YHI) n_overlap++;
        end
        rsp_prev = RSP_VALID;
        ylo_prev = MB_YLO;
        yhi_prev = MB_YHI;
        rdy_prev = CMD_READY;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge E6MHZ);
        #1;
    endtask

    task automatic offer_cmd(input logic [7:0] a, input logic [7:0] d, input logic rb, output bit ok);
        int n;
        n = 0;
        @(posedge E6MHZ); #1;
        CMD_VALID = 1'b1; CMD_ADDR = a; CMD_DATA = d; CMD_READBACK = rb;
        @(negedge E6MHZ);
        while (!CMD_READY && n < 3000) begin @(negedge E6MHZ); n++; end
        ok = CMD_READY;
        @(posedge E6MHZ); #1;
        CMD_VALID = 1'b0;
    endtask

    // Expected response cycle: BUSY begins 8 cycles after accept, then RDLO, RDHI, RESP.
    function automatic int exp_rsp_cycle(input int acc);
        int c;
        c = acc + 8;
        while (c < 65535 && !stop_hist[c]) c++;
        return c + 3;
    endfunction

    task automatic run_cmd(input vec_t v, input string tag);
        int nm0, nr0, ny0, nh0, n;
        bit ok;
        mb_result = v.result;
        mb_len = v.len;
        nm0 = n_mst; nr0 = n_rsp; ny0 = n_ylo; nh0 = n_yhi;
        offer_cmd(v.addr, v.data, v.rb, ok);
        check({tag, " accept"}, 32'(ok), 32'd1);
        check({tag, " eab"}, 32'(MB_EAB), 32'(v.addr));
        check({tag, " edb"}, 32'(MB_EDB), 32'(v.data));
        if (v.rb) begin
            n = 0;
            while (n_rsp == nr0 && n < 3000) begin @(posedge E6MHZ); n++; end
            wait_cycles(2);
            check({tag, " rsp count"}, 32'(n_rsp - nr0), 32'd1);
            check({tag, " rsp data"}, 32'(rsp_cap), 32'(v.exp_data));
            check({tag, " rsp timeout"}, 32'(rsp_to_cap), 32'd0);
            if (v.lat != 0) check({tag, " latency"}, 32'(rsp_cyc - acc_cyc), 32'(v.lat));
            else check({tag, " rsp cycle"}, 32'(rsp_cyc), 32'(exp_rsp_cycle(acc_cyc)));
            check({tag, " ylo strobes"}, 32'(n_ylo - ny0), 32'd1);
            check({tag, " yhi strobes"}, 32'(n_yhi - nh0), 32'd1);
        end else begin
            n = 0;
            while (!CMD_READY && n < 100) begin @(negedge E6MHZ); n++; end
            wait_cycles(3);
            check({tag, " ready return"}, 32'(rdy_cyc - acc_cyc), 32'd4);
            check({tag, " no rsp"}, 32'(n_rsp - nr0), 32'd0);
        end
        check({tag, " mstart width"}, 32'(mst_width), 32'd2);
        check({tag, " mstart pulses"}, 32'(n_mst - nm0), 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        vec_t rv;
        bit ok;
        int n, nr0, ny0, nacc0, bad_data, bad_rdy;

        vecs[0] = '{8'h15, 8'h3C, 1'b0, 16'h0000, 0,  0,  16'h0000};
        vecs[1] = '{8'h22, 8'h81, 1'b1, 16'h1234, 40, 0,  16'h1234};
        vecs[2] = '{8'h05, 8'hFF, 1'b1, 16'hA55A, 0,  11, 16'hA55A};
        vecs[3] = '{8'h7F, 8'h00, 1'b0, 16'h0000, 0,  0,  16'h0000};
        vecs[4] = '{8'h80, 8'h55, 1'b1, 16'h00FF, 3,  11, 16'h00FF};
        vecs[5] = '{8'hFE, 8'h01, 1'b1, 16'hFF00, 12, 0,  16'hFF00};

        repeat (3) @(negedge E6MHZ);
        check("reset cmd_ready", 32'(CMD_READY), 32'd1);
        check("reset rsp_valid", 32'(RSP_VALID), 32'd0);
        check("reset rsp_data", 32'(RSP_DATA), 32'd0);
        check("reset rsp_timeout", 32'(RSP_TIMEOUT), 32'd0);
        check("reset mb outputs", 32'({MB_EAB, MB_EDB, MB_MSTART, MB_YLO, MB_YHI}), 32'd0);
        RESET_N = 1'b1;
        wait_cycles(2);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            rv.addr = 8'($urandom);
            rv.data = 8'($urandom);
            rv.rb = 1'($urandom);
            rv.result = 16'($urandom);
            rv.len = $urandom_range(0, 60);
            rv.lat = 0;
            rv.exp_data = rv.result;
            run_cmd(rv, $sformatf("rnd%0d", i));
        end

        // Response back-pressure with a second command already offered.
        RSP_READY = 1'b0;
        mb_result = 16'hBEEF;
        mb_len = 10;
        nr0 = n_rsp;
        offer_cmd(8'h20, 8'h01, 1'b1, ok);
        n = 0;
        while (n_rsp == nr0 && n < 500) begin @(posedge E6MHZ); n++; end
        check("bp rsp data", 32'(rsp_cap), 32'h0000BEEF);
        @(posedge E6MHZ); #1;
        CMD_VALID = 1'b1; CMD_ADDR = 8'h21; CMD_DATA = 8'h02; CMD_READBACK = 1'b0;
        nacc0 = n_acc;
        bad_data = 0;
        bad_rdy = 0;
        repeat (20) begin
            @(negedge E6MHZ);
            if (RSP_DATA !== 16'hBEEF || RSP_VALID !== 1'b1) bad_data++;
            if (CMD_READY !== 1'b0) bad_rdy++;
        end
        check("bp data stable", 32'(bad_data), 32'd0);
        check("bp cmd_ready low", 32'(bad_rdy), 32'd0);
        check("bp no accept", 32'(n_acc - nacc0), 32'd0);
        @(posedge E6MHZ); #1;
        RSP_READY = 1'b1;
        n = 0;
        while (n_acc == nacc0 && n < 20) begin @(negedge E6MHZ); n++; end
        @(posedge E6MHZ); #1;
        CMD_VALID = 1'b0;
        check("bp second accept", 32'(n_acc - nacc0), 32'd1);
        check("bp accept after hs", 32'(acc_cyc), 32'(hs_cyc + 1));
        check("bp second eab", 32'(MB_EAB), 32'h21);
        wait_cycles(10);

`ifdef MB_HOST_TIMEOUT_EN
        mb_hang = 1;
        mb_result = 16'h5A5A;
        nr0 = n_rsp;
        ny0 = n_ylo;
        offer_cmd(8'h30, 8'h00, 1'b1, ok);
        n = 0;
        while (n_rsp == nr0 && n < 1500) begin @(posedge E6MHZ); n++; end
        wait_cycles(2);
        check("to rsp count", 32'(n_rsp - nr0), 32'd1);
        check("to rsp data", 32'(rsp_cap), 32'h0000FFFF);
        check("to rsp flag", 32'(rsp_to_cap), 32'd1);
        check("to latency", 32'(rsp_cyc - acc_cyc), 32'd1032);
        check("to no strobes", 32'(n_ylo - ny0), 32'd0);
        mb_hang = 0;
        wait_cycles(2);
`else
        mb_hang = 1;
        nr0 = n_rsp;
        offer_cmd(8'h30, 8'h00, 1'b1, ok);
        wait_cycles(5000);
        check("hang no rsp", 32'(n_rsp - nr0), 32'd0);
        check("hang cmd_ready", 32'(CMD_READY), 32'd0);
        check("hang rsp_timeout", 32'(RSP_TIMEOUT), 32'd0);
        mb_hang = 0;
        @(negedge E6MHZ);
        RESET_N = 1'b0;
        repeat (2) @(negedge E6MHZ);
        RESET_N = 1'b1;
        wait_cycles(2);
`endif

        // Reset while the low-byte strobe is active.
        mb_len = 0;
        mb_result = 16'hC0DE;
        offer_cmd(8'h40, 8'h11, 1'b1, ok);
        n = 0;
        @(negedge E6MHZ);
        while (!MB_YLO && n < 50) begin @(negedge E6MHZ); n++; end
        check("rst6 ylo reached", 32'(MB_YLO), 32'd1);
        #1 RESET_N = 1'b0;
        #1;
        check("rst6 ylo async drop", 32'(MB_YLO), 32'd0);
        check("rst6 yhi low", 32'(MB_YHI), 32'd0);
        check("rst6 rsp_valid", 32'(RSP_VALID), 32'd0);
        check("rst6 cmd_ready", 32'(CMD_READY), 32'd1);
        repeat (2) @(negedge E6MHZ);
        RESET_N = 1'b1;
        nr0 = n_rsp;
        wait_cycles(15);
        check("rst6 no rsp after", 32'(n_rsp - nr0), 32'd0);
        check("rst6 ready after", 32'(CMD_READY), 32'd1);

        run_cmd('{8'h99, 8'h66, 1'b1, 16'h4321, 5, 0, 16'h4321}, "post");

        check("ylo yhi overlap", 32'(n_overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
